mult_sequencer: RTL and testbench

- Control FSM that drives the sequential signed multiplier datapath: `load`, `psel`, `reg_en` and `shift_en`.
- Accepts a one-cycle `start`, and on each iteration branches on the datapath status bits `zflag` and `lsb_multiplier`.
- Signals completion with a `done` pulse and a held `result_valid`.
- Sits directly upstream of the multiplier, between the top-level operand/command interface and the datapath.

---
 rtl/mult_pkg.sv | 16 +
 rtl/mult_sequencer_if.sv | 31 +++
 rtl/mult_iter_counter.sv | 28 ++
 rtl/mult_sequencer.sv | 90 +++++++++
 tb/tb_mult_sequencer.sv | 154 +++++++++++++++
 5 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential signed multiplier control path.
package mult_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        CHECK = 3'd2,
        ADD   = 3'd3,
        SHIFT = 3'd4,
        DONE  = 3'd5
    } seq_state_t;

    localparam logic PSEL_CLEAR = 1'b0;
    localparam logic PSEL_ACCUM = 1'b1;

endpackage : mult_pkg

// File: rtl/mult_sequencer_if.sv
// Command, datapath status and datapath strobe bundle between sequencer and multiplier.
interface mult_sequencer_if #(
    parameter int unsigned CNT_W = 4
);
    logic             start;
    logic             zflag;
    logic             lsb_multiplier;
    logic             load;
    logic             psel;
    logic             reg_en;
    logic             shift_en;
    logic             busy;
    logic             done;
    logic             result_valid;
    logic             overflow_err;
    logic [CNT_W-1:0] iter_count;

    // Sequencer side: consumes command/status, drives strobes and status flags.
    modport master (
        input  start, zflag, lsb_multiplier,
        output load, psel, reg_en, shift_en,
        output busy, done, result_valid, overflow_err, iter_count
    );

    modport slave (
        output start, zflag, lsb_multiplier,
        input  load, psel, reg_en, shift_en,
        input  busy, done, result_valid, overflow_err, iter_count
    );

endinterface : mult_sequencer_if

// File: rtl/mult_iter_counter.sv
// Saturating shift counter with synchronous clear and enable.
module mult_iter_counter #(
    parameter int unsigned MAX_ITER = 8,
    parameter int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             at_max
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_ITER);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en && (count != CNT_MAX)) begin
            count <= count + CNT_W'(1);
        end
    end

    assign at_max = (count == CNT_MAX);

endmodule : mult_iter_counter

// File: rtl/mult_sequencer.sv
// Control FSM for the shift-and-add signed multiplier: sequences load/add/shift
// from datapath status and reports completion, busy and iteration overflow.
module mult_sequencer
    import mult_pkg::*;
#(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned MAX_ITER = WIDTH,
    parameter int unsigned CNT_W    = $clog2(MAX_ITER + 1)
) (
    input  logic              clk,
    input  logic              rst_n,
    mult_sequencer_if.master  bus
);

    seq_state_t state;
    seq_state_t next_state;
    logic       at_max;
    logic       set_ovf_c;

    mult_iter_counter #(
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) u_iter_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (state == LOAD),
        .en     (state == SHIFT),
        .count  (bus.iter_count),
        .at_max (at_max)
    );

    // Next-state logic; zflag has priority over the iteration ceiling.
    always_comb begin
        next_state = state;
        set_ovf_c  = 1'b0;
        unique case (state)
            IDLE:  if (bus.start) next_state = LOAD;
            LOAD:  next_state = CHECK;
            CHECK: begin
                if (bus.zflag) begin
                    next_state = DONE;
                end else if (at_max) begin
                    next_state = DONE;
                    set_ovf_c  = 1'b1;
                end else if (bus.lsb_multiplier) begin
                    next_state = ADD;
                end else begin
                    next_state = SHIFT;
                end
            end
            ADD:   next_state = SHIFT;
            SHIFT: next_state = CHECK;
            DONE:  next_state = bus.start ? LOAD : IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they track the state register exactly.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state            <= IDLE;
            bus.load         <= 1'b0;
            bus.psel         <= 1'b0;
            bus.reg_en       <= 1'b0;
            bus.shift_en     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.result_valid <= 1'b0;
            bus.overflow_err <= 1'b0;
        end else begin
            state        <= next_state;
            bus.load     <= (next_state == LOAD);
            bus.psel     <= (next_state == LOAD) ? PSEL_CLEAR : PSEL_ACCUM;
            bus.reg_en   <= (next_state == LOAD) || (next_state == ADD);
            bus.shift_en <= (next_state == SHIFT);
            bus.busy     <= (next_state == LOAD) || (next_state == CHECK) ||
                            (next_state == ADD)  || (next_state == SHIFT);
            bus.done     <= (next_state == DONE);

            if (next_state == LOAD) begin
                bus.result_valid <= 1'b0;
                bus.overflow_err <= 1'b0;
            end else if (next_state == DONE) begin
                bus.result_valid <= 1'b1;
                if (set_ovf_c) bus.overflow_err <= 1'b1;
            end
        end
    end

endmodule : mult_sequencer

// File: tb/tb_mult_sequencer.sv
// Directed self-checking bench for mult_sequencer with a small multiplier shift-register model.
module tb_mult_sequencer;

    localparam int unsigned WIDTH    = 8;
    localparam int unsigned MAX_ITER = 8;
    localparam int unsigned CNT_W    = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    mult_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mult_sequencer #(
        .WIDTH    (WIDTH),
        .MAX_ITER (MAX_ITER),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Multiplier magnitude register model; 'stuck' pins zflag=0, lsb=1.
    logic [WIDTH-1:0] mreg   = '0;
    logic [WIDTH-1:0] mag_in = '0;
    logic             stuck  = 1'b0;

    always @(posedge clk) begin
        if (bus.load)          mreg <= mag_in;
        else if (bus.shift_en) mreg <= mreg >> 1;
    end

    assign bus.zflag          = stuck ? 1'b0 : (mreg == '0);
    assign bus.lsb_multiplier = stuck ? 1'b1 : mreg[0];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Walks cycles from index k0 until done; lat stays 0 on timeout.
    task automatic wait_done(input int k0, input int limit, input int pulse_at,
                             output int lat, output int adds, output int overlaps);
        lat = 0; adds = 0; overlaps = 0;
        for (int k = k0; k <= limit; k++) begin
            @(negedge clk);
            if (k == pulse_at)     bus.start = 1'b1;
            if (k == pulse_at + 1) bus.start = 1'b0;
            if (bus.reg_en && bus.psel)   adds++;
            if (bus.load && bus.shift_en) overlaps++;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input int mag, input logic stuck_m, input int pulse_at,
                          input int exp_lat, input int exp_iter, input logic exp_ovf,
                          input int exp_adds);
        int lat, adds, ovl;
        @(negedge clk);
        mag_in    = WIDTH'(mag);
        stuck     = stuck_m;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check({tag, ".load"},     32'(bus.load), 1);
        check({tag, ".psel_ld"},  32'(bus.psel), 0);
        check({tag, ".rv_clr"},   32'(bus.result_valid), 0);
        check({tag, ".ovf_clr"},  32'(bus.overflow_err), 0);
        wait_done(2, 60, pulse_at, lat, adds, ovl);
        check({tag, ".latency"},  32'(lat), 32'(exp_lat));
        check({tag, ".iter"},     32'(bus.iter_count), 32'(exp_iter));
        check({tag, ".ovf"},      32'(bus.overflow_err), 32'(exp_ovf));
        check({tag, ".rv"},       32'(bus.result_valid), 1);
        check({tag, ".busy"},     32'(bus.busy), 0);
        check({tag, ".adds"},     32'(adds), 32'(exp_adds));
        check({tag, ".overlap"},  32'(ovl), 0);
    endtask

    initial begin
        int lat, adds, ovl;
        bus.start = 1'b1;

        // Reset with start asserted
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.load",   32'(bus.load), 0);
        check("rst.psel",   32'(bus.psel), 0);
        check("rst.reg_en", 32'(bus.reg_en), 0);
        check("rst.shift",  32'(bus.shift_en), 0);
        check("rst.busy",   32'(bus.busy), 0);
        check("rst.done",   32'(bus.done), 0);
        check("rst.rv",     32'(bus.result_valid), 0);
        check("rst.ovf",    32'(bus.overflow_err), 0);
        check("rst.iter",   32'(bus.iter_count), 0);
        rst_n     = 1'b1;
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("idle.load",  32'(bus.load), 0);
        check("idle.busy",  32'(bus.busy), 0);
        check("idle.psel",  32'(bus.psel), 1);

        run_op("mag0",   0,   1'b0, 0, 3,  0, 1'b0, 0);
        run_op("mag5",   5,   1'b0, 5, 11, 3, 1'b0, 2);
        run_op("mag128", 128, 1'b0, 0, 20, 8, 1'b0, 1);
        run_op("stuck",  1,   1'b1, 0, 27, 8, 1'b1, 8);
        stuck = 1'b0;
        run_op("clr_ovf", 0,  1'b0, 0, 3,  0, 1'b0, 0);

        // Back-to-back: start while in DONE
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        check("b2b.load", 32'(bus.load), 1);
        check("b2b.rv",   32'(bus.result_valid), 0);
        check("b2b.busy", 32'(bus.busy), 1);
        wait_done(2, 60, 0, lat, adds, ovl);
        check("b2b.latency", 32'(lat), 3);

        // Reset asserted while in ADD
        @(negedge clk);
        mag_in    = WIDTH'(5);
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (3) @(negedge clk);
        check("radd.in_add", 32'(bus.reg_en && bus.psel), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check("radd.busy",   32'(bus.busy), 0);
        check("radd.reg_en", 32'(bus.reg_en), 0);
        check("radd.done",   32'(bus.done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("radd.idle",   32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_mult_sequencer
